// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e     : 4-bit op codes carried in ex_md_op (9-15 decode as NONE)
//   - md_state_e  : IDLE/BUSY state of the divide sequencer
//   - DIV_ITERS   : restoring-division iterations per divide
//   - mag32()     : magnitude of a 32-bit operand, optionally two's-complement signed
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    // Absolute value when the operand is interpreted as signed; raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        mag32 = (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit_div_core.sv
// div_core: unsigned 32/32 restoring divider, one quotient bit per clock.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load a (dividend) and b (divisor) magnitudes; ignored while busy
//   busy       : iterating
//   done       : one-cycle pulse, quo/rem valid while it is high (and until next start)
//   quo, rem   : unsigned quotient and remainder
// A zero divisor is not special-cased: every trial subtract succeeds, so the
// quotient comes out all ones and the remainder equals the dividend.
module div_core
    import md_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [CNT_W-1:0] count_q;
    logic [31:0]      divisor_q;
    logic [31:0]      quo_q;      // dividend bits shift out the top, quotient bits in the bottom
    logic [31:0]      rem_q;
    logic             busy_q;
    logic             done_q;

    logic [32:0]      shifted;
    logic [33:0]      diff;
    logic             last_iter;

    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        diff      = {1'b0, shifted} - {2'b00, divisor_q};
        last_iter = busy_q && (count_q == CNT_W'(DIV_ITERS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                busy_q    <= 1'b1;
                count_q   <= '0;
                divisor_q <= b;
                quo_q     <= a;
                rem_q     <= '0;
            end else if (busy_q) begin
                // Negative trial difference: restore (keep shifted value), quotient bit 0.
                if (diff[33]) begin
                    rem_q <= shifted[31:0];
                    quo_q <= {quo_q[30:0], 1'b0};
                end else begin
                    rem_q <= diff[31:0];
                    quo_q <= {quo_q[30:0], 1'b1};
                end
                count_q <= count_q + 1'b1;
                if (last_iter) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit sitting beside the EX stage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ex_nop              : EX slot is a bubble (op ignored, md_result forced 0)
//   cu_stall, cu_flush  : pipeline frozen / EX squashed; block new ops only
//   ex_md_op            : md_op_e code from ID/EX
//   ex_op_A, ex_op_B    : rs / rt operands after forwarding
//   md_result           : HI for MFHI, LO for MFLO, else 0 (combinational)
//   md_busy             : divider sequencer is in BUSY (this is the FSM state)
//   md_stall            : stall request while an md op waits on a running divide
//   hi, lo              : architectural HI/LO
// Handshake: an op is taken (accept) on the edge where it is a valid md op and
// neither bubble, stall, flush nor md_stall blocks it. md_stall only rises in
// BUSY, so accept implies IDLE. Once a divide is taken it completes regardless
// of later stall/flush; only reset abandons it.
// Divide timing: start at accept edge, 32 iterations in div_core, results are
// sign-fixed and written on the following edge -> 33 busy cycles.
module md_unit
    import md_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_nop,
    input  logic        cu_stall,
    input  logic        cu_flush,
    input  logic [3:0]  ex_md_op,
    input  logic [31:0] ex_op_A,
    input  logic [31:0] ex_op_B,
    output logic [31:0] md_result,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, lo_q;
    logic        neg_quo_q, neg_rem_q;

    logic        op_valid, is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
    logic        accept, div_start;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_fix, rem_fix;

    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem;

    // Op decode; codes 9-15 fall through as NONE.
    always_comb begin
        op_valid = 1'b1;
        is_mult  = 1'b0;
        is_multu = 1'b0;
        is_div   = 1'b0;
        is_divu  = 1'b0;
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        case (ex_md_op)
            MD_MULT:  is_mult  = 1'b1;
            MD_MULTU: is_multu = 1'b1;
            MD_DIV:   is_div   = 1'b1;
            MD_DIVU:  is_divu  = 1'b1;
            MD_MTHI:  is_mthi  = 1'b1;
            MD_MTLO:  is_mtlo  = 1'b1;
            MD_MFHI, MD_MFLO: ;
            default:  op_valid = 1'b0;
        endcase
    end

    always_comb begin
        md_busy   = (state_q == ST_BUSY);
        md_stall  = md_busy && !ex_nop && op_valid;
        accept    = op_valid && !ex_nop && !cu_stall && !cu_flush && !md_stall;
        div_start = accept && (is_div || is_divu);

        // Explicit sign extension keeps the signed product exact in 64 bits.
        prod_s = $signed({{32{ex_op_A[31]}}, ex_op_A}) * $signed({{32{ex_op_B[31]}}, ex_op_B});
        prod_u = {32'd0, ex_op_A} * {32'd0, ex_op_B};

        quo_fix = neg_quo_q ? (~div_quo + 32'd1) : div_quo;
        rem_fix = neg_rem_q ? (~div_rem + 32'd1) : div_rem;

        md_result = 32'd0;
        if (!ex_nop) begin
            if (ex_md_op == MD_MFHI)
                md_result = hi_q;
            else if (ex_md_op == MD_MFLO)
                md_result = lo_q;
        end
    end

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (div_start) state_d = ST_BUSY;
            ST_BUSY: if (div_done && !div_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (div_start) begin
                // Quotient negative when signs differ; remainder follows the dividend.
                neg_quo_q <= is_div && (ex_op_A[31] ^ ex_op_B[31]);
                neg_rem_q <= is_div && ex_op_A[31];
            end
            if ((state_q == ST_BUSY) && div_done) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else if (accept) begin
                if (is_mult)       {hi_q, lo_q} <= prod_s;
                else if (is_multu) {hi_q, lo_q} <= prod_u;
                else if (is_mthi)  hi_q <= ex_op_A;
                else if (is_mtlo)  lo_q <= ex_op_A;
            end
        end
    end

    div_core u_div_core (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .a     (mag32(ex_op_A, is_div)),
        .b     (mag32(ex_op_B, is_div)),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo),
        .rem   (div_rem)
    );

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_nop;
    logic        cu_stall;
    logic        cu_flush;
    logic [3:0]  ex_md_op;
    logic [31:0] ex_op_A;
    logic [31:0] ex_op_B;
    logic [31:0] md_result;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_q[$];   // expected {hi, lo} for each division in flight

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    md_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ex_nop    (ex_nop),
        .cu_stall  (cu_stall),
        .cu_flush  (cu_flush),
        .ex_md_op  (ex_md_op),
        .ex_op_A   (ex_op_A),
        .ex_op_B   (ex_op_B),
        .md_result (md_result),
        .md_busy   (md_busy),
        .md_stall  (md_stall),
        .hi        (hi),
        .lo        (lo)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_md_op = op;
        ex_op_A  = a;
        ex_op_B  = b;
        #1;
    endtask

    // Issue a divide, optionally raise flush+stall while it runs, count busy
    // cycles and compare the final HI/LO against the scoreboard entry.
    task automatic run_div(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input bit disrupt);
        int n;
        logic [63:0] e;
        exp_q.push_back({e_hi, e_lo});
        drive(op, a, b);
        step();
        cu_flush = disrupt;
        cu_stall = disrupt;
        drive(MD_NONE, 32'd0, 32'd0);
        n = 0;
        while (md_busy && n < 100) begin
            step();
            n++;
        end
        cu_flush = 1'b0;
        cu_stall = 1'b0;
        check({tag, " busy_cycles"}, 32'(n), 32'd33);
        e = exp_q.pop_front();
        check({tag, " hi"}, hi, e[63:32]);
        check({tag, " lo"}, lo, e[31:0]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset    = 1'b1;
        ex_nop   = 1'b0;
        cu_stall = 1'b0;
        cu_flush = 1'b0;
        drive(MD_NONE, 32'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, md_busy}, 32'd0);
        check("reset stall", {31'd0, md_stall}, 32'd0);

        // Multiplies: one-cycle latency.
        drive(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        step();
        drive(MD_NONE, 32'd0, 32'd0);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFFA);
        drive(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        step();
        drive(MD_MFHI, 32'd0, 32'd0);
        check("multu hi", hi, 32'h0000_0002);
        check("multu lo", lo, 32'hFFFF_FFFA);
        check("mfhi result", md_result, 32'h0000_0002);
        ex_nop = 1'b1;
        #1;
        check("mfhi nop result", md_result, 32'd0);
        ex_nop = 1'b0;

        // Divides.
        run_div("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_div("divu 100/0", MD_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0);
        run_div("div 50/-7 disrupted", MD_DIV, 32'd50, 32'hFFFF_FFF9, 32'd1, 32'hFFFF_FFF9, 1'b1);

        // DIVU 10/3 with a non-md op and then MFLO behind it.
        drive(MD_DIVU, 32'd10, 32'd3);
        step();
        drive(MD_NONE, 32'd0, 32'd0);
        check("add during busy stall", {31'd0, md_stall}, 32'd0);
        check("add during busy busy", {31'd0, md_busy}, 32'd1);
        drive(MD_MFLO, 32'd0, 32'd0);
        check("mflo stall raised", {31'd0, md_stall}, 32'd1);
        n = 0;
        while (md_stall && n < 100) begin
            step();
            n++;
        end
        check("mflo stall cycles", 32'(n), 32'd33);
        check("mflo result", md_result, 32'd3);
        check("divu 10/3 hi", hi, 32'd1);
        drive(MD_NONE, 32'd0, 32'd0);

        // Blocked issues: flush, stall, bubble, undefined op.
        cu_flush = 1'b1;
        drive(MD_DIV, 32'd20, 32'd4);
        step();
        cu_flush = 1'b0;
        drive(MD_NONE, 32'd0, 32'd0);
        check("flushed div busy", {31'd0, md_busy}, 32'd0);
        step();
        check("flushed div hi", hi, 32'd1);
        check("flushed div lo", lo, 32'd3);
        cu_stall = 1'b1;
        drive(MD_MULT, 32'd5, 32'd5);
        step();
        cu_stall = 1'b0;
        drive(MD_NONE, 32'd0, 32'd0);
        check("stalled mult lo", lo, 32'd3);
        ex_nop = 1'b1;
        drive(MD_MTHI, 32'h1234, 32'd0);
        step();
        ex_nop = 1'b0;
        drive(MD_NONE, 32'd0, 32'd0);
        check("nop mthi hi", hi, 32'd1);
        drive(MD_MTHI, 32'h1234, 32'd0);
        step();
        drive(MD_MTLO, 32'h5678, 32'd0);
        check("mthi hi", hi, 32'h1234);
        step();
        drive(4'd9, 32'hDEAD_BEEF, 32'd7);
        check("mtlo lo", lo, 32'h5678);
        check("op9 result", md_result, 32'd0);
        step();
        check("op9 hi", hi, 32'h1234);
        check("op9 lo", lo, 32'h5678);

        // Reset partway through a divide.
        drive(MD_DIV, 32'd1000, 32'd3);
        step();
        drive(MD_NONE, 32'd0, 32'd0);
        repeat (10) step();
        check("pre-reset busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(MD_MFLO, 32'd0, 32'd0);
        check("mid reset busy", {31'd0, md_busy}, 32'd0);
        check("mid reset stall", {31'd0, md_stall}, 32'd0);
        check("mid reset hi", hi, 32'd0);
        check("mid reset lo", lo, 32'd0);
        drive(MD_NONE, 32'd0, 32'd0);
        repeat (30) step();
        check("post reset hi", hi, 32'd0);
        check("post reset lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 The block SHALL have port ex_nop, input, 1: EX slot holds a bubble; the block ignores ex_md_op when set.
REQ-004 The block SHALL have port cu_stall, input, 1: pipeline frozen; no new op is accepted.
REQ-005 The block SHALL have port cu_flush, input, 1: EX instruction squashed; no new op is accepted.
REQ-006 The block SHALL have port ex_md_op, input, 4: op code from the ID/EX register.
REQ-007 The block SHALL have ports ex_op_A and ex_op_B, input, 32 each: rs and rt operands after forwarding.
REQ-008 The block SHALL have port md_result, output, 32: HI for MFHI, LO for MFLO, else 0; combinational.
REQ-009 The block SHALL have port md_busy, output, 1: divider iterating.
REQ-010 The block SHALL have port md_stall, output, 1: stall request to the control unit.
REQ-011 The block SHALL have ports hi and lo, output, 32 each: architectural HI/LO registers.

Function
REQ-012 The block SHALL decode ex_md_op as: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 treated as NONE.
REQ-013 The block SHALL define accept = op!=NONE && !ex_nop && !cu_stall && !cu_flush && !md_stall.
REQ-014 On accept of MULT or MULTU, the block SHALL write {hi,lo} with the signed or unsigned 64-bit product at the same edge, with one-cycle latency and no busy cycles.
REQ-015 On accept of MTHI or MTLO, the block SHALL write ex_op_A into hi or lo respectively at the same edge.
REQ-016 On accept of DIV or DIVU, the block SHALL go from IDLE to BUSY, latch the operand magnitudes and sign flags, and clear a 6-bit counter.
REQ-017 In BUSY, the block SHALL perform one restoring-division iteration per cycle; after 32 iterations (count==31) it SHALL write lo=quotient and hi=remainder and return to IDLE, giving 33 cycles from accept edge to HI/LO valid.
REQ-018 For signed DIV, the block SHALL negate the quotient when operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-019 On divide by zero, the block SHALL produce magnitude quotient 0xFFFFFFFF and remainder equal to the dividend magnitude, with the signed fixups then applied; no trap is raised.
REQ-020 The block SHALL assert md_busy exactly while in BUSY.
REQ-021 The block SHALL assert md_stall when in BUSY && !ex_nop && ex_md_op!=NONE; ops that are not md ops SHALL proceed during BUSY.
REQ-022 MFHI or MFLO SHALL read the registered hi/lo, so a write at edge N is visible to a read in cycle N+1.
REQ-023 Once started, a division SHALL run to completion; cu_flush and cu_stall SHALL NOT abort it.
REQ-024 The block SHALL drive md_result by the ex_md_op decode regardless of accept, and SHALL drive 0 when ex_nop is set.

Reset
REQ-025 While reset is sampled high, the block SHALL set the state to IDLE, counter=0, hi=0, lo=0, and all datapath registers to 0; md_busy=0 and md_stall=0.
REQ-026 Reset asserted mid-division SHALL abandon the division with no HI/LO write.

Structure
REQ-027 A shared package SHALL hold the md_op encodings (REQ-012), the IDLE/BUSY state encoding, and the DIV_ITERS=32 constant.
REQ-028 The iterative divider (counter, partial remainder, quotient shift register) SHALL be a sub-module div_core with start, a, b, busy, done, quo, rem ports; md_unit SHALL own sign handling, HI/LO, and stall.

Verification
REQ-029 The bench SHALL check: MULT A=0xFFFFFFFE(-2), B=3 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-030 The bench SHALL check: DIV A=-7, B=2 -> md_busy for 33 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
REQ-031 The bench SHALL check: DIVU A=100, B=0 -> after 33 cycles lo=0xFFFFFFFF, hi=100.
REQ-032 The bench SHALL check: DIVU 10/3 followed by MFLO -> md_stall high until the done edge, then md_result=3; an ADD during BUSY sees md_stall=0.
REQ-033 The bench SHALL check: DIV issued with cu_flush=1 -> not started, hi/lo unchanged; MTHI 0x1234 with ex_nop=1 -> hi unchanged.
REQ-034 The bench SHALL check: reset at iteration 10 of a DIV -> next cycle state IDLE, hi=lo=0, md_busy=0.
